// File: rtl/stack_reg_file.sv
// Register file with a hardware stack pointer register, sticky stack error
// bits and a per-bit enabled flag register.
module stack_reg_file #(
  parameter int unsigned              DATA_W      = 16,
  parameter int unsigned              ADDR_W      = 4,
  parameter int unsigned              SP_IDX      = 2,
  parameter int unsigned              FLAG_W      = 3,
  parameter logic [DATA_W-1:0]        STACK_BASE  = 16'hFFFF,
  parameter logic [DATA_W-1:0]        STACK_LIMIT = 16'hFF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic [DATA_W-1:0] sp_out,
  output logic              stk_ovf,
  output logic              stk_unf,
  input  logic              flag_upd,
  input  logic [FLAG_W-1:0] flag_en,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [FLAG_W-1:0] flags_out
);

  localparam int unsigned       NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] SP_A  = ADDR_W'(SP_IDX);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] sp;
  logic [DATA_W-1:0] sp_next;
  logic              ovf_set;
  logic              unf_set;
  logic              sp_written;

  assign sp         = regs[SP_A];
  assign sp_out     = sp;
  assign sp_written = wr_en && (wr_addr == SP_A);

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_en) begin
      rd_data_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : regs[rd_addr_a];
      rd_data_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : regs[rd_addr_b];
    end
  end

  // An explicit SP write wins over any step; limits gate every step, so an
  // SP written outside [LIMIT, BASE] only ever moves back toward the range.
  always_comb begin
    sp_next = sp;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (sp_written) begin
      sp_next = wr_data;
    end else if (push && !pop) begin
      if (sp > STACK_LIMIT) sp_next = sp - DATA_W'(1);
      else                  ovf_set = 1'b1;
    end else if (pop && !push) begin
      if (sp < STACK_BASE)  sp_next = sp + DATA_W'(1);
      else                  unf_set = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      regs[SP_A] <= STACK_BASE;
    end else begin
      if (wr_en) regs[wr_addr] <= wr_data;
      regs[SP_A] <= sp_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stk_ovf   <= 1'b0;
      stk_unf   <= 1'b0;
      flags_out <= '0;
    end else begin
      stk_ovf <= ovf_set | (stk_ovf & ~err_clr);
      stk_unf <= unf_set | (stk_unf & ~err_clr);
      if (flag_upd) flags_out <= (flags_out & ~flag_en) | (flags_in & flag_en);
    end
  end

endmodule

// File: doc/stack_reg_file.md
STACK_REG_FILE -- requirements
Module: stack_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register and data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4: register address width; register count NREGS = 2^ADDR_W.
REQ-003 SHALL have parameter SP_IDX, default 2: index of the register used as stack pointer (SP).
REQ-004 SHALL have parameter FLAG_W, default 3: number of flag bits.
REQ-005 SHALL have parameter STACK_BASE, default 16'hFFFF: SP reset value and empty position; must be >= STACK_LIMIT.
REQ-006 SHALL have parameter STACK_LIMIT, default 16'hFF00: lowest legal SP value, the full position.
REQ-007 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have ports rd_en input 1, rd_addr_a input ADDR_W, rd_addr_b input ADDR_W: read enable and two read addresses.
REQ-010 SHALL have ports rd_data_a output DATA_W, rd_data_b output DATA_W: read data.
REQ-011 SHALL have ports wr_en input 1, wr_addr input ADDR_W, wr_data input DATA_W: write port.
REQ-012 SHALL have ports push input 1, pop input 1: stack pointer step requests.
REQ-013 SHALL have port err_clr, input, 1: clears the sticky stack error bits.
REQ-014 SHALL have ports sp_out output DATA_W, stk_ovf output 1, stk_unf output 1: current SP value and sticky overflow/underflow bits.
REQ-015 SHALL have ports flag_upd input 1, flag_en input FLAG_W, flags_in input FLAG_W, flags_out output FLAG_W: flag update strobe, per-bit enables, new flag values, registered flags.

Function
REQ-016 Reads SHALL be combinational: rd_data_x = reg[rd_addr_x] when rd_en=1, else all zero.
REQ-017 Write-through bypass: when rd_en=1, wr_en=1 and wr_addr==rd_addr_x, rd_data_x SHALL equal wr_data in the same cycle.
REQ-018 When wr_en=1, reg[wr_addr] SHALL take wr_data at the rising edge; latency is 1 cycle. rd_en does not gate writes.
REQ-019 Push alone SHALL work as follows: if SP > STACK_LIMIT, SP becomes SP-1 at the edge; if SP == STACK_LIMIT, SP holds and stk_ovf sets.
REQ-020 Pop alone SHALL work as follows: if SP < STACK_BASE, SP becomes SP+1; if SP == STACK_BASE, SP holds and stk_unf sets.
REQ-021 push=1 and pop=1 together SHALL leave SP unchanged and set no error bit.
REQ-022 wr_en=1 with wr_addr==SP_IDX SHALL take priority over push/pop: SP becomes wr_data, the step is dropped, and no error bit sets, even for out-of-range values.
REQ-023 SP arithmetic SHALL be unsigned DATA_W bits with no wrap-around; the limits in REQ-019 and REQ-020 always gate the step.
REQ-024 stk_ovf and stk_unf SHALL be sticky until err_clr=1 at an edge; a set event in the same cycle as err_clr wins, so the bit remains 1.
REQ-025 sp_out SHALL continuously reflect reg[SP_IDX].
REQ-026 When flag_upd=1, each flags_out[i] with flag_en[i]=1 SHALL take flags_in[i] at the edge; bits with flag_en[i]=0 hold.
REQ-027 When flag_upd=0, flags_out SHALL hold regardless of flag_en.

Reset
REQ-028 On reset=1, without waiting for a clock edge, all registers SHALL clear to 0 except reg[SP_IDX] = STACK_BASE; flags_out = 0; stk_ovf = stk_unf = 0.
REQ-029 Reset asserted mid-operation SHALL override any same-cycle write, push, pop or flag update.
REQ-030 After reset deasserts, the first rising edge SHALL perform normal operation.

Verification
REQ-031 Write/read: write 16'hA5A5 to r5, then rd_en=1 with rd_addr_a=5 and rd_addr_b=5 -> both outputs read 16'hA5A5; rd_en=0 -> both outputs read 0.
REQ-032 Bypass: wr_en=1, wr_addr=7, wr_data=16'h1234, rd_addr_a=7 in the same cycle -> rd_data_a=16'h1234 before the edge.
REQ-033 Stack bounds: from reset, pop -> SP stays 16'hFFFF and stk_unf=1; then 255 pushes -> SP=16'hFF00; one more push -> SP stays 16'hFF00 and stk_ovf=1; err_clr -> both error bits 0.
REQ-034 Conflicts: push and pop together -> SP unchanged and no error; wr_en to r2 with data 16'h0010 plus push -> SP=16'h0010 and no error.
REQ-035 Flags: flag_upd=1, flag_en=3'b101, flags_in=3'b111 -> flags_out=3'b101; flag_upd=0, flag_en=3'b111, flags_in=3'b010 -> flags_out stays 3'b101.
REQ-036 Async reset: assert reset between clock edges after writes -> registers and flags read 0 and SP reads 16'hFFFF immediately, with no clock edge.
